// File: rtl/byte_unstriper.sv
// Receive-side lane deskew and word reassembly: per-lane elastic FIFOs aligned on COM (K28.5),
// then one byte per lane is popped each cycle and packed into 32-bit words per group of four lanes.
module byte_unstriper #(
    parameter int num_lanes  = 4,
    parameter int max_skew   = 6,
    parameter int fifo_depth = max_skew + 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [num_lanes*8-1:0] i_lane_byte,
    input  logic [num_lanes-1:0]   i_lane_d_k,
    input  logic [num_lanes-1:0]   i_lane_valid,
    output logic [num_lanes*8-1:0] o_word,
    output logic [num_lanes-1:0]   o_d_k,
    output logic                   o_valid,
    output logic                   o_aligned,
    output logic                   o_skew_err
);

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_W = $clog2(fifo_depth + 1);
    localparam int SKW_W = $clog2(max_skew + 1) + 1;
    localparam logic [8:0] COM_SYM = 9'h1BC;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(fifo_depth - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = ptr + PTR_W'(1);
        end
    endfunction

    logic [8:0]       mem_r    [num_lanes][fifo_depth];
    logic [PTR_W-1:0] rd_ptr_r [num_lanes];
    logic [PTR_W-1:0] wr_ptr_r [num_lanes];
    logic [CNT_W-1:0] count_r  [num_lanes];
    state_t           state_r;
    logic [SKW_W-1:0] skew_cnt_r;

    logic [8:0]             head_s [num_lanes];
    logic [num_lanes-1:0]   not_empty_s, head_com_s, full_s, pop_s, write_s, overflow_s, dk_s;
    logic                   all_ne_s, all_com_s, partial_s, skew_fail_s, misalign_s, error_s, emit_s;
    logic [num_lanes*8-1:0] word_s;

    // Per-lane head inspection and word packing (lane 4g+0 lands in the most significant byte)
    always_comb begin
        word_s      = {(num_lanes*8){1'b0}};
        dk_s        = {num_lanes{1'b0}};
        not_empty_s = {num_lanes{1'b0}};
        head_com_s  = {num_lanes{1'b0}};
        full_s      = {num_lanes{1'b0}};
        for (int l = 0; l < num_lanes; l++) begin
            head_s[l]      = mem_r[l][rd_ptr_r[l]];
            not_empty_s[l] = (count_r[l] != {CNT_W{1'b0}});
            head_com_s[l]  = not_empty_s[l] && (head_s[l] == COM_SYM);
            full_s[l]      = (count_r[l] == CNT_W'(fifo_depth));
            word_s[32*(l/4) + 8*(3 - (l%4)) +: 8] = head_s[l][7:0];
            dk_s[l]        = head_s[l][8];
        end
    end

    // Pop selection and error detection for the current state
    always_comb begin
        all_ne_s    = &not_empty_s;
        all_com_s   = &head_com_s;
        partial_s   = (|head_com_s) && !all_com_s;
        skew_fail_s = 1'b0;
        misalign_s  = 1'b0;
        pop_s       = {num_lanes{1'b0}};
        case (state_r)
            SEARCH: begin
                // The counter sits at max_skew on the cycle a further partial hold would exceed it
                skew_fail_s = partial_s && (skew_cnt_r == SKW_W'(max_skew));
                if (all_com_s) begin
                    pop_s = {num_lanes{1'b1}};
                end else begin
                    pop_s = not_empty_s & ~head_com_s;
                end
            end
            ALIGNED: begin
                misalign_s = all_ne_s && partial_s;
                if (all_ne_s) begin
                    pop_s = {num_lanes{1'b1}};
                end else begin
                    pop_s = {num_lanes{1'b0}};
                end
            end
            default: begin
                pop_s = {num_lanes{1'b0}};
            end
        endcase
        write_s    = i_lane_valid & (~full_s | pop_s);
        overflow_s = i_lane_valid & full_s & ~pop_s;
        error_s    = (|overflow_s) || skew_fail_s || misalign_s;
        if (state_r == SEARCH) begin
            emit_s = !error_s && all_com_s;
        end else begin
            emit_s = !error_s && all_ne_s;
        end
    end

    // FIFO storage; stale entries are harmless since a flush only rewinds the pointers
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < num_lanes; l++) begin
            if (write_s[l]) begin
                mem_r[l][wr_ptr_r[l]] <= {i_lane_d_k[l], i_lane_byte[8*l +: 8]};
            end
        end
    end

    // FIFO pointers and occupancy, flushed on any alignment error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int l = 0; l < num_lanes; l++) begin
                rd_ptr_r[l] <= {PTR_W{1'b0}};
                wr_ptr_r[l] <= {PTR_W{1'b0}};
                count_r[l]  <= {CNT_W{1'b0}};
            end
        end else begin
            for (int l = 0; l < num_lanes; l++) begin
                if (error_s) begin
                    rd_ptr_r[l] <= {PTR_W{1'b0}};
                    wr_ptr_r[l] <= {PTR_W{1'b0}};
                    count_r[l]  <= {CNT_W{1'b0}};
                end else begin
                    if (write_s[l]) begin
                        wr_ptr_r[l] <= ptr_inc(wr_ptr_r[l]);
                    end
                    if (pop_s[l]) begin
                        rd_ptr_r[l] <= ptr_inc(rd_ptr_r[l]);
                    end
                    count_r[l] <= count_r[l] + CNT_W'(write_s[l]) - CNT_W'(pop_s[l]);
                end
            end
        end
    end

    // Alignment FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= SEARCH;
            skew_cnt_r <= {SKW_W{1'b0}};
            o_word     <= {(num_lanes*8){1'b0}};
            o_d_k      <= {num_lanes{1'b0}};
            o_valid    <= 1'b0;
            o_aligned  <= 1'b0;
            o_skew_err <= 1'b0;
        end else begin
            o_skew_err <= error_s;
            o_valid    <= emit_s;
            if (emit_s) begin
                o_word <= word_s;
                o_d_k  <= dk_s;
            end
            case (state_r)
                SEARCH: begin
                    if (error_s) begin
                        skew_cnt_r <= {SKW_W{1'b0}};
                        o_aligned  <= 1'b0;
                    end else if (all_com_s) begin
                        state_r    <= ALIGNED;
                        skew_cnt_r <= {SKW_W{1'b0}};
                        o_aligned  <= 1'b1;
                    end else if (partial_s) begin
                        skew_cnt_r <= skew_cnt_r + SKW_W'(1);
                        o_aligned  <= 1'b0;
                    end else begin
                        skew_cnt_r <= {SKW_W{1'b0}};
                        o_aligned  <= 1'b0;
                    end
                end
                ALIGNED: begin
                    skew_cnt_r <= {SKW_W{1'b0}};
                    if (error_s) begin
                        state_r   <= SEARCH;
                        o_aligned <= 1'b0;
                    end else begin
                        o_aligned <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= SEARCH;
                    skew_cnt_r <= {SKW_W{1'b0}};
                    o_aligned  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_unstriper.sv
// Directed bench for byte_unstriper: a lane-queue scoreboard predicts every output word,
// with inline checks for latency, skew errors, stall bubbles, overflow and reset.
module tb_byte_unstriper;

    localparam int NL = 4;
    localparam int MS = 6;
    localparam int FD = MS + 2;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [NL*8-1:0] i_lane_byte;
    logic [NL-1:0]   i_lane_d_k;
    logic [NL-1:0]   i_lane_valid;
    logic [NL*8-1:0] o_word;
    logic [NL-1:0]   o_d_k;
    logic            o_valid;
    logic            o_aligned;
    logic            o_skew_err;

    byte_unstriper #(.num_lanes(NL), .max_skew(MS), .fifo_depth(FD)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_lane_byte  (i_lane_byte),
        .i_lane_d_k   (i_lane_d_k),
        .i_lane_valid (i_lane_valid),
        .o_word       (o_word),
        .o_d_k        (o_d_k),
        .o_valid      (o_valid),
        .o_aligned    (o_aligned),
        .o_skew_err   (o_skew_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int nv_cnt = 0;
    int err_cnt = 0;
    logic [NL-1:0] track = 4'h0;
    logic [8:0]    lq [NL][$];
    logic [35:0]   exp_q [$];

    function automatic logic [31:0] lanes(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < NL; l++) lq[l].delete();
        exp_q.delete();
    endtask

    task automatic monitor();
        logic [35:0] e;
        if (o_skew_err) err_cnt++;
        if (!o_valid) nv_cnt++;
        if (o_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed=%0h expected=none", o_word);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_word", 64'({o_d_k, o_word}), 64'(e));
            end
        end
    endtask

    // Drive one symbol time, predict words, sample outputs at the falling edge
    task automatic step(input logic [31:0] bytes, input logic [3:0] dk, input logic [3:0] vld);
        logic [8:0]  s;
        logic [31:0] w;
        logic [3:0]  k;
        i_lane_byte  = bytes;
        i_lane_d_k   = dk;
        i_lane_valid = vld;
        for (int l = 0; l < NL; l++)
            if (vld[l] && track[l]) lq[l].push_back({dk[l], bytes[8*l +: 8]});
        while (lq[0].size() != 0 && lq[1].size() != 0 && lq[2].size() != 0 && lq[3].size() != 0) begin
            for (int l = 0; l < NL; l++) begin
                s = lq[l].pop_front();
                w[8*(3-l) +: 8] = s[7:0];
                k[l] = s[8];
            end
            exp_q.push_back({k, w});
        end
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 4'h0, 4'h0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_lane_byte = 32'h0;
        i_lane_d_k = 4'h0;
        i_lane_valid = 4'h0;

        // Reset held with random lane activity
        for (int i = 0; i < 4; i++) begin
            i_lane_byte  = $urandom();
            i_lane_d_k   = 4'($urandom());
            i_lane_valid = 4'($urandom());
            @(posedge i_clk);
            #1;
            check("reset_outputs", 64'({o_word, o_d_k, o_valid, o_aligned, o_skew_err}), 64'h0);
        end
        i_lane_valid = 4'h0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // No COM: must stay unaligned with no output
        for (int i = 0; i < 6; i++) begin
            step($urandom(), 4'h0, 4'hF);
            check("nocom_aligned", 64'(o_aligned), 64'h0);
            check("nocom_valid", 64'(o_valid), 64'h0);
        end

        // Skew 3: lane 0 COM first, lanes 1-3 three symbol times later
        err_cnt = 0;
        track = 4'h1;
        step(lanes(8'hBC, 8'h00, 8'h00, 8'h00), 4'h1, 4'hF);
        step(lanes(8'hA0, 8'h00, 8'h00, 8'h00), 4'h0, 4'hF);
        step(32'h0, 4'h0, 4'hE);
        track = 4'hF;
        step(lanes(8'h00, 8'hBC, 8'hBC, 8'hBC), 4'hE, 4'hE);
        step(lanes(8'h00, 8'hA1, 8'hA2, 8'hA3), 4'h0, 4'hE);
        check("skew3_com_valid", 64'(o_valid), 64'h1);
        check("skew3_com_word", 64'({o_d_k, o_word}), 64'hF_BCBCBCBC);
        idle(1);
        check("skew3_data_word", 64'({o_valid, o_d_k, o_word}), 64'h1_0_A0A1A2A3);
        check("skew3_aligned", 64'(o_aligned), 64'h1);

        // Stream, then a one-cycle stall on lane 2 gives exactly one bubble
        for (int i = 0; i < 4; i++) step($urandom(), 4'h0, 4'hF);
        nv_cnt = 0;
        step($urandom(), 4'h0, 4'hB);
        for (int i = 0; i < 5; i++) step($urandom(), 4'h0, 4'hF);
        check("stall_bubbles", 64'(nv_cnt), 64'h1);
        idle(3);
        check("stall_drained", 64'(exp_q.size()), 64'h0);
        check("skew3_no_err", 64'(err_cnt), 64'h0);

        // Long stall on lane 2 overflows the other lanes
        check("pre_ovf_aligned", 64'(o_aligned), 64'h1);
        track = 4'h0;
        clear_model();
        err_cnt = 0;
        for (int i = 0; i < FD + 1; i++) step($urandom(), 4'h0, 4'hB);
        check("ovf_err_pulses", 64'(err_cnt), 64'h1);
        check("ovf_aligned", 64'(o_aligned), 64'h0);
        idle(2);
        check("ovf_err_clear", 64'(o_skew_err), 64'h0);

        // Zero-skew alignment with exact latency
        track = 4'hF;
        step(lanes(8'hBC, 8'hBC, 8'hBC, 8'hBC), 4'hF, 4'hF);
        step(lanes(8'h11, 8'h22, 8'h33, 8'h44), 4'h0, 4'hF);
        check("zs_com", 64'({o_valid, o_aligned, o_d_k, o_word}), 64'h3_F_BCBCBCBC);
        step(lanes(8'h55, 8'h66, 8'h77, 8'h88), 4'h0, 4'hF);
        check("zs_data", 64'({o_valid, o_d_k, o_word}), 64'h1_0_11223344);
        step($urandom(), 4'h0, 4'hF);
        check("zs_data2", 64'({o_valid, o_d_k, o_word}), 64'h1_0_55667788);
        step($urandom(), 4'h0, 4'hF);

        // COM on lanes 0-1 only while aligned
        track = 4'h0;
        step(lanes(8'hBC, 8'hBC, 8'h01, 8'h02), 4'h3, 4'hF);
        idle(1);
        check("mis_err", 64'(o_skew_err), 64'h1);
        check("mis_valid", 64'(o_valid), 64'h0);
        check("mis_aligned", 64'(o_aligned), 64'h0);
        idle(1);
        check("mis_err_pulse", 64'(o_skew_err), 64'h0);
        check("mis_drained", 64'(exp_q.size()), 64'h0);

        // Excess skew: lanes 1-3 COM max_skew+2 symbol times after lane 0
        idle(2);
        err_cnt = 0;
        step(lanes(8'hBC, 8'h00, 8'h00, 8'h00), 4'h1, 4'hF);
        check("xs_aligned0", 64'(o_aligned), 64'h0);
        for (int i = 0; i < MS + 1; i++) begin
            step(32'h0, 4'h0, 4'hF);
            check("xs_aligned", 64'(o_aligned), 64'h0);
        end
        step(lanes(8'h00, 8'hBC, 8'hBC, 8'hBC), 4'hE, 4'hF);
        for (int i = 0; i < 4; i++) begin
            step(32'h0, 4'h0, 4'h0);
            check("xs_aligned_late", 64'(o_aligned), 64'h0);
        end
        check("xs_err_pulses", 64'(err_cnt), 64'h1);
        idle(12);

        // Subsequent zero-skew COM aligns normally
        clear_model();
        track = 4'hF;
        step(lanes(8'hBC, 8'hBC, 8'hBC, 8'hBC), 4'hF, 4'hF);
        step(lanes(8'hC1, 8'hC2, 8'hC3, 8'hC4), 4'h0, 4'hF);
        check("realign_com", 64'({o_valid, o_aligned, o_d_k, o_word}), 64'h3_F_BCBCBCBC);
        for (int i = 0; i < 3; i++) step($urandom(), 4'h0, 4'hF);
        check("realign_aligned", 64'(o_aligned), 64'h1);

        // Asynchronous reset in the middle of a symbol time
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", 64'({o_word, o_d_k, o_valid, o_aligned, o_skew_err}), 64'h0);
        track = 4'h0;
        clear_model();
        i_lane_valid = 4'h0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            step($urandom(), 4'h0, 4'hF);
            check("post_reset_aligned", 64'(o_aligned), 64'h0);
            check("post_reset_valid", 64'(o_valid), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
